// File: rtl/veritune_audio_rx_if.sv
// Sample stream handshake between the audio receiver and its consumer.
// The receiver drives valid/data/channel, and the consumer drives ready.
interface veritune_audio_rx_if #(
    parameter int unsigned DATA_W = 16
);
    logic              Sample_Valid;
    logic              Sample_Ready;
    logic [DATA_W-1:0] Sample_Data;
    logic              Sample_Chan;

    modport master (
        output Sample_Valid,
        output Sample_Data,
        output Sample_Chan,
        input  Sample_Ready
    );

    modport slave (
        input  Sample_Valid,
        input  Sample_Data,
        input  Sample_Chan,
        output Sample_Ready
    );
endinterface

// File: rtl/veritune_audio_rx.sv
// I2S ADC capture: synchronizes the codec clocks, deserializes one word per half-frame,
// and queues {channel, word} samples in a small FIFO with sticky error flags.
module veritune_audio_rx #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        board_clk,
    input  logic                        Reset,
    input  logic                        SCLK,
    input  logic                        LRCK,
    input  logic                        SDOUT,
    input  logic                        Enable,
    input  logic                        Clr_Err,
    veritune_audio_rx_if.master         smp,
    output logic [$clog2(FIFO_DEPTH):0] Level,
    output logic                        Overrun,
    output logic                        Frame_Err
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LastBit = CW'(DATA_W - 1);
    localparam logic [LW-1:0] FullLvl = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StSkip, StShift, StWait} state_e;

    logic sclk_s1_q, sclk_s2_q, sclk_p_q;
    logic lrck_s1_q, lrck_s2_q, lrck_p_q;
    logic sdout_s1_q, sdout_s2_q;

    state_e            state_q, state_d;
    logic              chan_q, chan_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W:0]   mem_q [FIFO_DEPTH];
    logic [DATA_W:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ovr_q, ovr_d, ferr_q, ferr_d;

    logic            sclk_rise, lrck_edge, push, pop, full, wr_en, ovr_evt, ferr_evt;
    logic [DATA_W:0] push_word;

    always_comb begin
        sclk_rise = sclk_s2_q & ~sclk_p_q;
        lrck_edge = lrck_s2_q ^ lrck_p_q;
        state_d   = state_q;
        chan_d    = chan_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        ferr_evt  = 1'b0;
        push_word = {chan_q, shift_q[DATA_W-2:0], sdout_s2_q};

        // Word-select edges outrank a coincident bit-clock rise.
        if (!Enable) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (lrck_edge) begin
            state_d  = StSkip;
            chan_d   = lrck_s2_q;
            cnt_d    = '0;
            ferr_evt = (state_q == StSkip) || (state_q == StShift);
        end else if (sclk_rise) begin
            case (state_q)
                StSkip:  state_d = StShift;
                StShift: begin
                    shift_d = {shift_q[DATA_W-2:0], sdout_s2_q};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LastBit) begin
                        push    = 1'b1;
                        state_d = StWait;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pop      = (level_q != '0) & smp.Sample_Ready;
        full     = (level_q == FullLvl);
        wr_en    = push & (~full | pop);
        ovr_evt  = push & full & ~pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = push_word;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // A same-cycle error event wins over the clear.
        ovr_d  = (Clr_Err ? 1'b0 : ovr_q) | ovr_evt;
        ferr_d = (Clr_Err ? 1'b0 : ferr_q) | ferr_evt;
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            sclk_s1_q  <= 1'b0;
            sclk_s2_q  <= 1'b0;
            sclk_p_q   <= 1'b0;
            lrck_s1_q  <= 1'b0;
            lrck_s2_q  <= 1'b0;
            lrck_p_q   <= 1'b0;
            sdout_s1_q <= 1'b0;
            sdout_s2_q <= 1'b0;
            state_q    <= StIdle;
            chan_q     <= 1'b0;
            cnt_q      <= '0;
            shift_q    <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sclk_s1_q  <= SCLK;
            sclk_s2_q  <= sclk_s1_q;
            sclk_p_q   <= sclk_s2_q;
            lrck_s1_q  <= LRCK;
            lrck_s2_q  <= lrck_s1_q;
            lrck_p_q   <= lrck_s2_q;
            sdout_s1_q <= SDOUT;
            sdout_s2_q <= sdout_s1_q;
            state_q    <= state_d;
            chan_q     <= chan_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign smp.Sample_Valid = (level_q != '0);
    assign smp.Sample_Data  = mem_q[rd_ptr_q][DATA_W-1:0];
    assign smp.Sample_Chan  = mem_q[rd_ptr_q][DATA_W];
    assign Level            = level_q;
    assign Overrun          = ovr_q;
    assign Frame_Err        = ferr_q;
endmodule

// File: tb/tb_veritune_audio_rx.sv
// Directed bench for veritune_audio_rx: drives I2S half-frames of 24 SCLK periods
// (8 board clocks each) and checks the sample FIFO, error flags and reset behaviour.
module tb_veritune_audio_rx;
    logic       board_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic       SCLK      = 1'b0;
    logic       LRCK      = 1'b1;
    logic       SDOUT     = 1'b0;
    logic       Enable    = 1'b0;
    logic       Clr_Err   = 1'b0;
    logic [2:0] Level;
    logic       Overrun;
    logic       Frame_Err;

    int compared   = 0;
    int mismatched = 0;

    veritune_audio_rx_if #(.DATA_W(16)) smp_if ();

    veritune_audio_rx #(
        .DATA_W    (16),
        .FIFO_DEPTH(4)
    ) dut (
        .board_clk(board_clk),
        .Reset    (Reset),
        .SCLK     (SCLK),
        .LRCK     (LRCK),
        .SDOUT    (SDOUT),
        .Enable   (Enable),
        .Clr_Err  (Clr_Err),
        .smp      (smp_if.master),
        .Level    (Level),
        .Overrun  (Overrun),
        .Frame_Err(Frame_Err)
    );

    always #5 board_clk = ~board_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One SCLK period starting at a negedge; optionally pulse Sample_Ready so it is
    // high at the board edge that acts on this period's SCLK rise.
    task automatic sclk_period(input logic lr, input logic sd, input bit rdy_pulse);
        SCLK  = 1'b0;
        LRCK  = lr;
        SDOUT = sd;
        repeat (4) @(negedge board_clk);
        SCLK = 1'b1;
        repeat (2) @(negedge board_clk);
        if (rdy_pulse) smp_if.Sample_Ready = 1'b1;
        @(negedge board_clk);
        smp_if.Sample_Ready = 1'b0;
        @(negedge board_clk);
    endtask

    // Periods first..last-1 of an I2S half-frame: period 0 is the delay bit,
    // periods 1..16 carry the word MSB first.
    task automatic send_half(input logic ch, input logic [15:0] w, input int first,
                             input int last, input int rdy_k);
        for (int k = first; k < last; k++) begin
            sclk_period(ch, (k >= 1 && k <= 16) ? w[16-k] : 1'b0, k == rdy_k);
        end
    endtask

    task automatic send_word(input logic ch, input logic [15:0] w);
        send_half(ch, w, 0, 24, -1);
    endtask

    task automatic check_pop(input string tag, input logic ch, input logic [15:0] w);
        check({tag, ".valid"}, {31'd0, smp_if.Sample_Valid}, 32'd1);
        check({tag, ".chan"}, {31'd0, smp_if.Sample_Chan}, {31'd0, ch});
        check({tag, ".data"}, {16'd0, smp_if.Sample_Data}, {16'd0, w});
        smp_if.Sample_Ready = 1'b1;
        @(negedge board_clk);
        smp_if.Sample_Ready = 1'b0;
    endtask

    task automatic pulse_clr();
        Clr_Err = 1'b1;
        @(negedge board_clk);
        Clr_Err = 1'b0;
        @(negedge board_clk);
    endtask

    initial begin
        smp_if.Sample_Ready = 1'b0;
        repeat (3) @(negedge board_clk);
        check("rst.valid", {31'd0, smp_if.Sample_Valid}, 32'd0);
        check("rst.level", {29'd0, Level}, 32'd0);
        check("rst.data", {16'd0, smp_if.Sample_Data}, 32'd0);
        check("rst.ovr", {31'd0, Overrun}, 32'd0);
        check("rst.ferr", {31'd0, Frame_Err}, 32'd0);
        Reset = 1'b0;
        repeat (5) @(negedge board_clk);
        Enable = 1'b1;

        // Basic stereo frame
        send_word(1'b0, 16'hA5C3);
        send_word(1'b1, 16'h7F01);
        check("frame.level", {29'd0, Level}, 32'd2);
        check_pop("frame.p0", 1'b0, 16'hA5C3);
        check_pop("frame.p1", 1'b1, 16'h7F01);
        check("frame.empty", {29'd0, Level}, 32'd0);
        check("frame.ferr", {31'd0, Frame_Err}, 32'd0);

        // Overrun: fifth word dropped
        send_word(1'b0, 16'h0001);
        send_word(1'b1, 16'h8000);
        send_word(1'b0, 16'hFFFF);
        send_word(1'b1, 16'h5A5A);
        check("ovr.level4", {29'd0, Level}, 32'd4);
        check("ovr.pre", {31'd0, Overrun}, 32'd0);
        send_word(1'b0, 16'hC0DE);
        check("ovr.level", {29'd0, Level}, 32'd4);
        check("ovr.set", {31'd0, Overrun}, 32'd1);
        check_pop("ovr.p0", 1'b0, 16'h0001);
        check_pop("ovr.p1", 1'b1, 16'h8000);
        check_pop("ovr.p2", 1'b0, 16'hFFFF);
        check_pop("ovr.p3", 1'b1, 16'h5A5A);
        check("ovr.empty", {31'd0, smp_if.Sample_Valid}, 32'd0);
        pulse_clr();
        check("ovr.clr", {31'd0, Overrun}, 32'd0);

        // Full FIFO with pop coinciding with push
        send_word(1'b1, 16'h1111);
        send_word(1'b0, 16'h2222);
        send_word(1'b1, 16'h3333);
        send_word(1'b0, 16'h4444);
        check("full.level", {29'd0, Level}, 32'd4);
        send_half(1'b1, 16'h5555, 0, 24, 16);
        check("full.level_after", {29'd0, Level}, 32'd4);
        check("full.ovr", {31'd0, Overrun}, 32'd0);
        check_pop("full.p0", 1'b0, 16'h2222);
        check_pop("full.p1", 1'b1, 16'h3333);
        check_pop("full.p2", 1'b0, 16'h4444);
        check_pop("full.p3", 1'b1, 16'h5555);
        check("full.empty", {29'd0, Level}, 32'd0);

        // Early LRCK toggle after 10 bits
        send_half(1'b0, 16'hFFFF, 0, 11, -1);
        send_word(1'b1, 16'h1234);
        check("ferr.level", {29'd0, Level}, 32'd1);
        check("ferr.set", {31'd0, Frame_Err}, 32'd1);
        check_pop("ferr.p0", 1'b1, 16'h1234);
        pulse_clr();
        check("ferr.clr", {31'd0, Frame_Err}, 32'd0);

        // Enable dropped after 8 bits, re-raised mid half-frame
        send_half(1'b0, 16'h00FF, 0, 9, -1);
        Enable = 1'b0;
        repeat (4) @(negedge board_clk);
        Enable = 1'b1;
        send_half(1'b0, 16'h00FF, 9, 24, -1);
        check("en.level", {29'd0, Level}, 32'd0);
        check("en.ferr", {31'd0, Frame_Err}, 32'd0);
        send_word(1'b1, 16'hBEEF);
        check("en.level1", {29'd0, Level}, 32'd1);
        check_pop("en.p0", 1'b1, 16'hBEEF);

        // Reset mid-word with two samples queued
        send_word(1'b0, 16'h1357);
        send_word(1'b1, 16'h2468);
        check("mrst.level2", {29'd0, Level}, 32'd2);
        send_half(1'b0, 16'hF0F0, 0, 8, -1);
        #3 Reset = 1'b1;
        #1;
        check("mrst.valid", {31'd0, smp_if.Sample_Valid}, 32'd0);
        check("mrst.level", {29'd0, Level}, 32'd0);
        check("mrst.data", {16'd0, smp_if.Sample_Data}, 32'd0);
        check("mrst.chan", {31'd0, smp_if.Sample_Chan}, 32'd0);
        check("mrst.ovr", {31'd0, Overrun}, 32'd0);
        check("mrst.ferr", {31'd0, Frame_Err}, 32'd0);
        repeat (3) @(negedge board_clk);
        Reset = 1'b0;
        send_half(1'b0, 16'hF0F0, 8, 24, -1);
        check("mrst.idle", {29'd0, Level}, 32'd0);
        send_word(1'b1, 16'h9ABC);
        check("mrst.level1", {29'd0, Level}, 32'd1);
        check_pop("mrst.p0", 1'b1, 16'h9ABC);
        check("mrst.ferr2", {31'd0, Frame_Err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/veritune_audio_rx.md
VERITUNE_AUDIO_RX -- requirements
Module: veritune_audio_rx

Interface
REQ-001 Parameter DATA_W, default 16, captured bits per channel word.
REQ-002 Parameter FIFO_DEPTH, default 4, sample FIFO entries (power of 2).
REQ-003 board_clk  input  1  system clock, rising-edge; all state in this domain.
REQ-004 Reset  input  1  asynchronous, active-high; clock board_clk.
REQ-005 SCLK  input  1  codec bit clock (divided clock), asynchronous to board_clk.
REQ-006 LRCK  input  1  codec word select; 0 = left, 1 = right.
REQ-007 SDOUT  input  1  codec serial ADC data, MSB first.
REQ-008 Enable  input  1  capture enable, level.
REQ-009 Clr_Err  input  1  single-cycle pulse; clears sticky error flags.
REQ-010 Sample_Ready  input  1  consumer accepts head sample this cycle.
REQ-011 Sample_Valid  output  1  FIFO non-empty; head sample presented.
REQ-012 Sample_Data  output  DATA_W  head sample data, two's complement as received.
REQ-013 Sample_Chan  output  1  head sample channel, 0 = left, 1 = right.
REQ-014 Level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-015 Overrun  output  1  sticky: sample dropped because FIFO full.
REQ-016 Frame_Err  output  1  sticky: LRCK changed before DATA_W bits captured.

Function
REQ-017 SCLK, LRCK and SDOUT SHALL each pass through a 2-flop synchronizer; all edge detection and sampling SHALL use the synchronized versions only.
REQ-018 SCLK rise = synchronized SCLK 0 in previous cycle, 1 in current cycle; LRCK edge = synchronized LRCK differs from previous cycle.
REQ-019 States: IDLE, SKIP, SHIFT, WAIT.
REQ-020 IDLE: leave only on LRCK edge while Enable=1 -> SKIP; latch channel = new LRCK value; clear bit counter.
REQ-021 SKIP: the first SCLK rise after an LRCK edge (I2S one-bit delay) SHALL be ignored -> SHIFT.
REQ-022 SHIFT: on each SCLK rise, shift SDOUT into LSB of the shift register and increment the bit counter; on the DATA_W-th rise, push {channel, word} into the FIFO -> WAIT.
REQ-023 WAIT: ignore further SCLK rises (codec bits beyond DATA_W are discarded).
REQ-024 LRCK edge in SKIP, SHIFT or WAIT SHALL -> SKIP with new channel latched; if in SKIP or SHIFT (word incomplete), discard the partial word and set Frame_Err.
REQ-025 LRCK edge and SCLK rise in the same cycle: LRCK edge handling SHALL take priority; the SCLK rise is not captured.
REQ-026 Enable=0 in any state SHALL -> IDLE next cycle, discarding any partial word without setting Frame_Err; FIFO contents SHALL be retained.
REQ-027 Push latency: FIFO entry visible (Level incremented, Sample_Valid=1 if previously empty) one cycle after the cycle of the DATA_W-th SCLK rise.
REQ-028 Pop: when Sample_Valid=1 and Sample_Ready=1, the head is removed at that clock edge; Sample_Ready with Sample_Valid=0 SHALL have no effect.
REQ-029 Push when Level=FIFO_DEPTH with no simultaneous pop: new sample dropped, FIFO unchanged, Overrun set.
REQ-030 Push and pop in the same cycle when full: both performed, Level unchanged, Overrun not set.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH; Level counts 0..FIFO_DEPTH inclusive.
REQ-032 Clr_Err clears Overrun and Frame_Err; an error event in the same cycle as Clr_Err SHALL leave the flag set.
REQ-033 Sample_Data and Sample_Chan are don't-care while Sample_Valid=0.

Reset
REQ-034 Reset SHALL asynchronously force: state IDLE, synchronizers 0, shift register 0, bit counter 0, FIFO pointers 0, Level=0, Sample_Valid=0, Sample_Data=0, Sample_Chan=0, Overrun=0, Frame_Err=0.
REQ-035 Reset mid-word SHALL discard the partial word; after release, capture resumes only after the next LRCK edge with Enable=1.

Verification
REQ-036 Enable=1, I2S frame left=16'hA5C3, right=16'h7F01, 24 SCLK per half-frame -> two pops in order: (Chan 0, 16'hA5C3), (Chan 1, 16'h7F01); Frame_Err=0.
REQ-037 Sample_Ready=0, 5 complete words sent -> Level=4 after the fourth, fifth dropped, Overrun=1; pops return words 1-4 in order; Clr_Err -> Overrun=0.
REQ-038 FIFO full, Sample_Ready=1 held through the fifth word's push cycle -> no Overrun, Level stays 4, word 5 appears as last pop.
REQ-039 LRCK toggles after 10 captured bits -> no push, Frame_Err=1, next complete word 16'h1234 captured correctly on new channel.
REQ-040 Enable dropped after 8 bits, re-raised mid-half-frame -> no push, Frame_Err=0, capture resumes at next LRCK edge.
REQ-041 Reset asserted mid-word with Level=2 -> all outputs per REQ-034 immediately; first post-reset pop is a full word started after an LRCK edge.
